// File: rtl/sensor_irq_pio_pkg.sv
// sensor_irq_pio_pkg
//   Shared definitions for the sensor_irq_pio interrupt input port:
//   register word addresses and the common register reset value.
package sensor_irq_pio_pkg;

   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_RISE_EN   = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
   localparam logic [2:0] ADDR_FALL_EN   = 3'd4;
   localparam logic [2:0] ADDR_DEBOUNCE  = 3'd5;
   localparam logic [2:0] ADDR_PENDING   = 3'd6;

   localparam logic [31:0] REG_RESET = '0;

endpackage

// File: rtl/sensor_irq_pio_debounce.sv
// sensor_irq_pio_debounce
//   One input channel: SYNC_STAGES-deep synchroniser, glitch filter with a
//   programmable stability threshold, filtered level and its one-cycle delay.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   din              asynchronous external line
//   thresh           filter threshold N (0 = no filtering)
//   filt             filtered level f
//   rise, fall       single-cycle edge pulses of f (f vs. f delayed)
module sensor_irq_pio_debounce
   import sensor_irq_pio_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DEBOUNCE_BITS = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     din,
   input  logic [DEBOUNCE_BITS-1:0] thresh,
   output logic                     filt,
   output logic                     rise,
   output logic                     fall
);

   localparam logic [DEBOUNCE_BITS-1:0] ONE = 1;

   logic [SYNC_STAGES-1:0]   sync;
   logic [DEBOUNCE_BITS-1:0] cnt;
   logic                     filt_d;
   logic                     s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync   <= '0;
         cnt    <= '0;
         filt   <= 1'b0;
         filt_d <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], din};
         filt_d <= filt;
         if (s == filt) begin
            cnt <= '0;
         end else if (thresh == '0 || cnt >= thresh - ONE) begin
            // >= rather than == so a threshold lowered mid-count still fires
            filt <= s;
            cnt  <= '0;
         end else begin
            cnt <= cnt + ONE;
         end
      end
   end

   assign rise = filt & ~filt_d;
   assign fall = ~filt & filt_d;

endmodule

// File: rtl/sensor_irq_pio.sv
// sensor_irq_pio
//   Multi-channel interrupt input port on an Avalon-MM slave. Each channel is
//   synchronised and debounced; rising/falling edges of the filtered level are
//   captured (write-1-to-clear) and combined with a mask into one level IRQ.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      Avalon-MM slave write/read request
//   readdata                registered read data (1-cycle latency)
//   in_port                 asynchronous external lines
//   irq                     interrupt request, active high
module sensor_irq_pio
   import sensor_irq_pio_pkg::*;
#(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned DEBOUNCE_BITS = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0]         filt, rise, fall;
   logic [WIDTH-1:0]         rise_en, irq_mask, edge_cap, fall_en;
   logic [DEBOUNCE_BITS-1:0] debounce;
   logic [WIDTH-1:0]         cap_set, cap_clr;
   logic [31:0]              rd_next;
   logic                     wr;
   logic                     unused_wdata;

   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sensor_irq_pio_debounce #(
         .SYNC_STAGES   (SYNC_STAGES),
         .DEBOUNCE_BITS (DEBOUNCE_BITS)
      ) u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (in_port[i]),
         .thresh  (debounce),
         .filt    (filt[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
      );
   end

   assign wr      = chipselect & ~write_n;
   assign cap_set = (rise_en & rise) | (fall_en & fall);
   assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_en  <= REG_RESET[WIDTH-1:0];
         irq_mask <= REG_RESET[WIDTH-1:0];
         edge_cap <= REG_RESET[WIDTH-1:0];
         fall_en  <= REG_RESET[WIDTH-1:0];
         debounce <= REG_RESET[DEBOUNCE_BITS-1:0];
      end else begin
         if (wr) begin
            unique case (address)
               ADDR_RISE_EN:  rise_en  <= writedata[WIDTH-1:0];
               ADDR_IRQ_MASK: irq_mask <= writedata[WIDTH-1:0];
               ADDR_FALL_EN:  fall_en  <= writedata[WIDTH-1:0];
               ADDR_DEBOUNCE: debounce <= writedata[DEBOUNCE_BITS-1:0];
               default: ;
            endcase
         end
         // set after clear so a new edge wins over a same-cycle W1C
         edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      end
   end

   always_comb begin
      rd_next = '0;
      unique case (address)
         ADDR_DATA:     rd_next[WIDTH-1:0]         = filt;
         ADDR_RISE_EN:  rd_next[WIDTH-1:0]         = rise_en;
         ADDR_IRQ_MASK: rd_next[WIDTH-1:0]         = irq_mask;
         ADDR_EDGE_CAP: rd_next[WIDTH-1:0]         = edge_cap;
         ADDR_FALL_EN:  rd_next[WIDTH-1:0]         = fall_en;
         ADDR_DEBOUNCE: rd_next[DEBOUNCE_BITS-1:0] = debounce;
         ADDR_PENDING:  rd_next[WIDTH-1:0]         = edge_cap & irq_mask;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= REG_RESET;
      else          readdata <= rd_next;
   end

   assign irq = |(edge_cap & irq_mask);

endmodule
